// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end with decoupled request and response channels, an in-order
// instruction queue and a registered decode-facing output stage. Flushes count off stale responses.
module if_fetch_queue #(
   parameter int                XLEN            = 32,
   parameter logic [XLEN-1:0]   RESET_PC        = 32'h8000_0000,
   parameter int                MAX_OUTSTANDING = 2,
   parameter int                FQ_DEPTH        = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_stall,
   input  logic            i_flush,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_req_valid,
   input  logic            i_req_ready,
   output logic [XLEN-1:0] o_req_addr,
   input  logic            i_rsp_valid,
   input  logic [XLEN-1:0] i_rsp_rdata,
   input  logic            i_rsp_err,
   output logic            o_if_valid,
   output logic [XLEN-1:0] o_if_pc,
   output logic [XLEN-1:0] o_if_instr,
   output logic            o_if_err
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int QW = $clog2(FQ_DEPTH + 1);
   localparam int PW = $clog2(FQ_DEPTH);

   logic [XLEN-1:0] req_pc;
   logic [XLEN-1:0] rsp_pc;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   drop_cnt;
   logic [QW-1:0]   q_count;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [QW:0]     committed;

   logic [XLEN-1:0] q_pc    [FQ_DEPTH];
   logic [XLEN-1:0] q_instr [FQ_DEPTH];
   logic            q_err   [FQ_DEPTH];

   logic req_fire;
   logic rsp_fire;
   logic push;
   logic pop;

   // Every live request holds a queue slot, so the queue can never overflow on a push.
   assign committed   = (QW+1)'(q_count) + (QW+1)'(inflight - drop_cnt);
   assign o_req_valid = !i_flush && (inflight < CW'(MAX_OUTSTANDING)) &&
                        (committed < (QW+1)'(FQ_DEPTH));
   assign o_req_addr  = req_pc;

   assign req_fire = o_req_valid && i_req_ready;
   assign rsp_fire = i_rsp_valid && (inflight != '0);
   assign push     = rsp_fire && !i_flush && (drop_cnt == '0);
   assign pop      = !i_flush && !i_stall && (q_count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_pc   <= RESET_PC;
         rsp_pc   <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
         q_count  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         if (i_flush) begin
            req_pc <= i_redirect_pc;
            rsp_pc <= i_redirect_pc;
         end else begin
            if (req_fire) req_pc <= req_pc + XLEN'(4);
            if (push)     rsp_pc <= rsp_pc + XLEN'(4);
         end

         if (req_fire && !rsp_fire)
            inflight <= inflight + CW'(1);
         else if (!req_fire && rsp_fire)
            inflight <= inflight - CW'(1);

         // A response arriving in the flush cycle is itself discarded, so it is not re-counted.
         if (i_flush)
            drop_cnt <= inflight - (rsp_fire ? CW'(1) : CW'(0));
         else if (rsp_fire && (drop_cnt != '0))
            drop_cnt <= drop_cnt - CW'(1);

         if (i_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
               q_count <= q_count + QW'(1);
            else if (!push && pop)
               q_count <= q_count - QW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wr_ptr]    <= rsp_pc;
         q_instr[wr_ptr] <= i_rsp_rdata;
         q_err[wr_ptr]   <= i_rsp_err;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_if_valid <= 1'b0;
         o_if_pc    <= '0;
         o_if_instr <= '0;
         o_if_err   <= 1'b0;
      end else if (i_flush) begin
         o_if_valid <= 1'b0;
      end else if (!i_stall) begin
         o_if_valid <= pop;
         if (pop) begin
            o_if_pc    <= q_pc[rd_ptr];
            o_if_instr <= q_instr[rd_ptr];
            o_if_err   <= q_err[rd_ptr];
         end
      end
   end

   a_rsp_needs_inflight: assert property (@(posedge clk) disable iff (!rst_n)
      i_rsp_valid |-> (inflight != '0));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized and directed bench for if_fetch_queue against a queue-based behavioural model
// and a latency-programmable in-order instruction memory.
module tb_if_fetch_queue;

   localparam int          MAXO     = 2;
   localparam int          FQD      = 4;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk, rst_n;
   logic        i_stall, i_flush, i_req_ready, i_rsp_valid, i_rsp_err;
   logic [31:0] i_redirect_pc, i_rsp_rdata;
   logic        o_req_valid, o_if_valid, o_if_err;
   logic [31:0] o_req_addr, o_if_pc, o_if_instr;

   if_fetch_queue #(.XLEN(32), .RESET_PC(RESET_PC), .MAX_OUTSTANDING(MAXO), .FQ_DEPTH(FQD)) dut (
      .clk(clk), .rst_n(rst_n), .i_stall(i_stall), .i_flush(i_flush),
      .i_redirect_pc(i_redirect_pc), .o_req_valid(o_req_valid), .i_req_ready(i_req_ready),
      .o_req_addr(o_req_addr), .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata),
      .i_rsp_err(i_rsp_err), .o_if_valid(o_if_valid), .o_if_pc(o_if_pc),
      .o_if_instr(o_if_instr), .o_if_err(o_if_err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {logic [31:0] pc; logic [31:0] instr; logic err;} ent_t;
   typedef struct {logic [31:0] addr; int due; logic err;} mreq_t;

   int n_tests = 0;
   int n_fail  = 0;

   // memory and stimulus state
   mreq_t       mem_q[$];
   int          cyc, lat_min, lat_max, err_mode, max_seen;
   logic        s_stall, s_flush, s_ready;
   logic [31:0] s_redir;
   logic        last_rsp_v;
   logic [31:0] last_rsp_addr;

   // behavioural model
   logic [31:0] m_req_pc, m_rsp_pc;
   int          m_infl, m_drop;
   ent_t        m_q[$];
   logic        m_ov, m_oerr;
   logic [31:0] m_opc, m_oinstr;

   function automatic logic [31:0] mem_data(logic [31:0] a);
      return (a ^ 32'h5A5A_1234) * 32'h0001_0003 + 32'h13;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_req_pc = RESET_PC; m_rsp_pc = RESET_PC;
      m_infl = 0; m_drop = 0; m_q.delete();
      m_ov = 1'b0; m_opc = '0; m_oinstr = '0; m_oerr = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      i_stall = 1'b0; i_flush = 1'b0; i_redirect_pc = '0; i_req_ready = 1'b0;
      i_rsp_valid = 1'b0; i_rsp_rdata = '0; i_rsp_err = 1'b0;
      s_stall = 1'b0; s_flush = 1'b0; s_redir = '0;
      repeat (2) @(negedge clk);
      chk("rst_if_valid", o_if_valid, 0);
      chk("rst_if_pc",    o_if_pc,    0);
      chk("rst_if_instr", o_if_instr, 0);
      chk("rst_if_err",   o_if_err,   0);
      mem_q.delete();
      model_reset();
      cyc = 0;
      rst_n = 1'b1;
   endtask

   // One clock cycle: drive at the negedge, compare, advance model and memory, wait for next negedge.
   task automatic cycle();
      logic        rv, re, exp_rv, hs, rsp;
      logic [31:0] rd, ra;
      mreq_t       nr;
      ent_t        e;
      rv = 1'b0; re = 1'b0; rd = '0; ra = '0;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         rv = 1'b1; ra = mem_q[0].addr; rd = mem_data(ra); re = mem_q[0].err;
      end
      i_stall = s_stall; i_flush = s_flush; i_redirect_pc = s_redir; i_req_ready = s_ready;
      i_rsp_valid = rv; i_rsp_rdata = rd; i_rsp_err = re;
      last_rsp_v = rv; last_rsp_addr = ra;
      #1;
      exp_rv = !s_flush && (m_infl < MAXO) && ((m_q.size() + m_infl - m_drop) < FQD);
      chk("req_valid", o_req_valid, exp_rv);
      if (exp_rv) chk("req_addr", o_req_addr, m_req_pc);
      chk("if_valid", o_if_valid, m_ov);
      chk("if_pc",    o_if_pc,    m_opc);
      chk("if_instr", o_if_instr, m_oinstr);
      chk("if_err",   o_if_err,   m_oerr);

      if (rv) void'(mem_q.pop_front());
      if (o_req_valid && s_ready) begin
         nr.addr = o_req_addr;
         nr.due  = cyc + $urandom_range(lat_min, lat_max);
         nr.err  = (err_mode == 0) ? (o_req_addr == 32'h8000_0008) : ($urandom_range(0, 7) == 0);
         mem_q.push_back(nr);
      end
      if (mem_q.size() > max_seen) max_seen = mem_q.size();

      hs  = exp_rv && s_ready;
      rsp = rv && (m_infl > 0);
      if (s_flush) begin
         m_ov = 1'b0;
         m_q.delete();
      end else if (!s_stall) begin
         if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_ov = 1'b1; m_opc = e.pc; m_oinstr = e.instr; m_oerr = e.err;
         end else begin
            m_ov = 1'b0;
         end
      end
      if (s_flush) begin
         m_drop   = m_infl - (rsp ? 1 : 0);
         m_req_pc = s_redir;
         m_rsp_pc = s_redir;
      end else if (rsp) begin
         if (m_drop > 0) m_drop--;
         else begin
            e.pc = m_rsp_pc; e.instr = rd; e.err = re;
            m_q.push_back(e);
            m_rsp_pc += 32'd4;
         end
      end
      if (hs) m_req_pc += 32'd4;
      m_infl += (hs ? 1 : 0) - (rsp ? 1 : 0);
      cyc++;
      @(negedge clk);
   endtask

   task automatic wait_first_valid(string name, logic [31:0] exp_pc, output int stale);
      logic found;
      found = 1'b0;
      stale = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         if (o_if_valid) found = 1'b1;
         else begin
            cycle();
            if (last_rsp_v && last_rsp_addr < exp_pc) stale++;
         end
      end
      chk({name, "_found"}, found, 1);
      if (found) begin
         chk({name, "_pc"},    o_if_pc,    exp_pc);
         chk({name, "_instr"}, o_if_instr, mem_data(exp_pc));
      end
   endtask

   initial begin
      logic [31:0] p;
      logic        found;
      int          stale;
      rst_n = 1'b0; s_ready = 1'b1; lat_min = 1; lat_max = 1; err_mode = 0; max_seen = 0;
      cyc = 0; last_rsp_v = 1'b0; last_rsp_addr = '0;
      @(negedge clk);
      do_reset();

      // streaming with 1-cycle memory, error injected at 0x8000_0008
      repeat (2) cycle();
      chk("lat_idle_valid", o_if_valid, 0);
      cycle();
      for (int i = 0; i < 8; i++) begin
         chk("strm_valid", o_if_valid, 1);
         chk("strm_pc",    o_if_pc,    32'h8000_0000 + 32'(4 * i));
         chk("strm_err",   o_if_err,   (i == 2) ? 32'd1 : 32'd0);
         cycle();
      end

      // stall fills the queue, then drains in order
      p = 32'h8000_0020;
      chk("pre_stall_pc", o_if_pc, p);
      s_stall = 1'b1;
      repeat (6) begin
         cycle();
         chk("stall_hold_valid", o_if_valid, 1);
         chk("stall_hold_pc",    o_if_pc,    p);
      end
      chk("stall_no_req", o_req_valid, 0);
      s_stall = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         cycle();
         chk("drain_valid", o_if_valid, 1);
         chk("drain_pc",    o_if_pc,    p + 32'(4 * i));
      end

      // 3-cycle memory latency caps at MAX_OUTSTANDING
      do_reset();
      lat_min = 3; lat_max = 3; max_seen = 0;
      repeat (60) cycle();
      chk("max_outstanding", max_seen, MAXO);

      // flush with two requests in flight and no response in the flush cycle
      do_reset();
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         if (mem_q.size() == 2) found = 1'b1; else cycle();
      end
      chk("flushA_setup", found, 1);
      s_flush = 1'b1; s_redir = 32'h8000_0100;
      cycle();
      s_flush = 1'b0;
      chk("flushA_if_valid", o_if_valid, 0);
      wait_first_valid("flushA_first", 32'h8000_0100, stale);
      chk("flushA_stale", stale, 2);

      // flush coinciding with a response, two in flight
      do_reset();
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (mem_q.size() == 2 && mem_q[0].due <= cyc) found = 1'b1; else cycle();
      end
      chk("flushB_setup", found, 1);
      s_flush = 1'b1; s_redir = 32'h8000_0200;
      cycle();
      s_flush = 1'b0;
      wait_first_valid("flushB_first", 32'h8000_0200, stale);
      chk("flushB_stale_after", stale, 1);

      // randomized traffic with a mid-run reset
      do_reset();
      lat_min = 1; lat_max = 4; err_mode = 1;
      for (int k = 0; k < 3000; k++) begin
         s_stall = ($urandom_range(0, 3) == 0);
         s_flush = ($urandom_range(0, 24) == 0);
         s_redir = $urandom() & 32'hFFFF_FFFC;
         s_ready = ($urandom_range(0, 3) != 0);
         if (k == 1500) do_reset();
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", n_tests, n_fail);
      $fatal(1);
   end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised instruction-fetch front end that replaces the single-entry fetch stage. It has decoupled request and response channels toward instruction memory and supports up to MAX_OUTSTANDING in-flight requests. Returned instructions are buffered in an FQ_DEPTH-entry in-order queue, which feeds a registered output stage into decode. A flush discards in-flight responses by counting them off, so redirects never leak stale instructions.

Parameters:
XLEN, 32, address and instruction width
RESET_PC, 32'h8000_0000, first fetch address after reset
MAX_OUTSTANDING, 2, maximum in-flight memory requests (power of 2, >=1)
FQ_DEPTH, 4, instruction queue entries (power of 2, >=2, >=MAX_OUTSTANDING)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
i_stall  in  1  decode not accepting; output stage holds
i_flush  in  1  redirect; kills queue, output and in-flight fetches
i_redirect_pc  in  XLEN  new fetch PC, sampled when i_flush=1
o_req_valid  out  1  fetch request valid
i_req_ready  in  1  memory accepts request; handshake = valid&&ready
o_req_addr  out  XLEN  fetch address (word aligned)
i_rsp_valid  in  1  response valid; in order, always accepted, 1 per request
i_rsp_rdata  in  XLEN  fetched instruction
i_rsp_err  in  1  access fault for this response
o_if_valid  out  1  instruction valid to decode
o_if_pc  out  XLEN  PC of o_if_instr
o_if_instr  out  XLEN  instruction
o_if_err  out  1  fetch fault flag for this instruction

Behaviour:
- Reset (async): req_pc=RESET_PC, rsp_pc=RESET_PC, inflight=0, drop_cnt=0, queue empty. o_if_valid=0, o_if_pc=0, o_if_instr=0, o_if_err=0.
- Counters use $clog2(N+1) bits. inflight counts all outstanding requests, including ones to be dropped.
- Request issue, combinational: o_req_valid = !i_flush && inflight<MAX_OUTSTANDING && (q_count + live_inflight) < FQ_DEPTH, where live_inflight = inflight - drop_cnt. This reserves a queue slot per live request, so the queue never overflows.
- o_req_addr = req_pc. On handshake, req_pc += 4 (mod 2^XLEN) and inflight += 1.
- Once asserted, o_req_valid and o_req_addr stay stable until the handshake. The only exception is a cycle with i_flush=1, where valid drops.
- Response, drop_cnt>0: the response is discarded, drop_cnt -= 1, inflight -= 1.
- Response, drop_cnt==0: push {rsp_pc, rdata, err} into the queue, rsp_pc += 4, inflight -= 1.
- A simultaneous request handshake and response leaves inflight unchanged.
- Output stage (registered), i_flush=1: o_if_valid <= 0.
- Output stage, !i_stall: if the queue is non-empty, pop the head into o_if_* and set o_if_valid <= 1; otherwise o_if_valid <= 0. o_if_pc/instr/err hold their last values when invalid.
- Output stage, i_stall && !i_flush: all o_if_* hold and there is no pop.
- A same-cycle push and pop on the queue is legal, including on a full queue with pop.
- Latency: a response accepted at edge E is visible on o_if at edge E+1 at the earliest (queue empty, no stall). There is no bypass.
- With 1-cycle memory latency and MAX_OUTSTANDING>=2, sustained throughput is 1 instruction/cycle.
- Flush (cycle with i_flush=1), effect at the edge:
  - req_pc <= i_redirect_pc and rsp_pc <= i_redirect_pc.
  - Queue is cleared and o_if_valid <= 0.
  - drop_cnt <= inflight - (i_rsp_valid ? 1 : 0). Any response arriving in the flush cycle is discarded.
  - No request is issued in the flush cycle. Requests resume the next cycle; the new requests count toward inflight alongside the pending drops.
- Back-to-back flushes: the last one wins. drop_cnt is recomputed each flush from inflight.
- Flush and stall together: flush has priority.
- i_rsp_err entries pass through like normal entries and fetching continues; decode raises the exception.
- Response with inflight==0: protocol violation. It is flagged by an assertion and ignored.
- Reset mid-operation clears all tracking. The memory must be reset by the same rst_n, so no pre-reset responses return.

Test Plan:
- Reset, i_req_ready=1, memory with 1-cycle latency, no stall -> requests at 0x8000_0000, 0x8000_0004, ... every cycle. o_if_valid=1 from the 3rd cycle on, with PCs incrementing by 4 and instructions matching the memory image.
- i_stall held 6 cycles with default params -> issue stops once q_count+inflight=4, the queue holds 4 entries, and o_if holds its value. On release, 4 queued instructions stream out in order with no gap or duplicate.
- Memory latency 3 cycles, MAX_OUTSTANDING=2 -> never more than 2 outstanding requests. Responses map to the correct PCs.
- 2 requests in flight, then i_flush with redirect 0x8000_0100 -> o_if_valid=0 the next cycle and both stale responses are dropped. The first output after the flush has PC 0x8000_0100.
- i_flush in the same cycle as i_rsp_valid, with 2 in flight -> drop_cnt=1, that response is discarded, and exactly one further response is discarded.
- Response with i_rsp_err=1 at PC 0x8000_0008 -> o_if_err=1 only for that PC. Subsequent fetches continue with err=0.
